// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding, the 3-bit digit decoder and the default width.
package booth_pkg;

  localparam int BOOTH_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_digit_t;

  // Maps the overlapping bit triple (b[2i+1], b[2i], b[2i-1]) to a digit in {-2..+2}.
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t digit;
    case (bits)
      3'b000:  digit = BD_ZERO;
      3'b001:  digit = BD_POS1;
      3'b010:  digit = BD_POS1;
      3'b011:  digit = BD_POS2;
      3'b100:  digit = BD_NEG2;
      3'b101:  digit = BD_NEG1;
      3'b110:  digit = BD_NEG1;
      3'b111:  digit = BD_ZERO;
      default: digit = BD_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: one Booth digit applied to the
// sign-extended multiplicand and weighted by 4^shift, modulo 2^(2*WIDTH).
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_DEFAULT_WIDTH,
  parameter int IDX_W = 4
) (
  input  logic [2:0]         bits,
  input  logic [2*WIDTH-1:0] a_ext,
  input  logic [IDX_W-1:0]   shift,
  output logic [2*WIDTH-1:0] pp
);

  localparam logic [2*WIDTH-1:0] PW_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] PW_ZERO = {(2*WIDTH){1'b0}};

  booth_digit_t       digit_s;
  logic [2*WIDTH-1:0] mult_s;
  logic [IDX_W:0]     shamt_s;

  // Select the digit multiple on the full extended width, negating as ~x+1, then weight it.
  always_comb begin
    digit_s = booth_decode(bits);
    case (digit_s)
      BD_ZERO: mult_s = PW_ZERO;
      BD_POS1: mult_s = a_ext;
      BD_POS2: mult_s = a_ext << 1;
      BD_NEG1: mult_s = ~a_ext + PW_ONE;
      BD_NEG2: mult_s = ~(a_ext << 1) + PW_ONE;
      default: mult_s = PW_ZERO;
    endcase
    shamt_s = {shift, 1'b0};
    pp      = mult_s << shamt_s;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed radix-4 Booth multiplier, one digit retired per clock, with
// valid/ready operand and result handshakes.
// Optional build macro BOOTH_MUL_SEQ_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all-zero or all-one (variable latency, identical product).
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  // Counter must reach WIDTH/2 in the fixed-latency build (one drain cycle after the last digit).
  localparam int IDX_W = $clog2(WIDTH / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);
`else
  localparam logic [IDX_W-1:0] DONE_IDX = IDX_W'(WIDTH / 2);
`endif
  localparam logic [2*WIDTH-1:0] PW_ZERO = {(2*WIDTH){1'b0}};

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] a_ext_q, a_ext_d;
  // Multiplier with appended zero LSB; shifted right 2 per digit so bits [2:0] are the current triple.
  logic [WIDTH:0]     b_sh_q, b_sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] pp_s;
  logic [2*WIDTH-1:0] acc_sum_s;

  booth_pp_gen #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pp_gen (
    .bits  (b_sh_q[2:0]),
    .a_ext (a_ext_q),
    .shift (idx_q),
    .pp    (pp_s)
  );

  assign acc_sum_s = acc_q + pp_s;

`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
  logic rest_uniform_s;
  // Remaining multiplier bits b[WIDTH-1:2i+1] all equal means every later digit is zero.
  always_comb begin
    if ((b_sh_q[WIDTH:2] == {(WIDTH-1){1'b0}}) || (b_sh_q[WIDTH:2] == {(WIDTH-1){1'b1}})) begin
      rest_uniform_s = 1'b1;
    end else begin
      rest_uniform_s = 1'b0;
    end
  end
`endif

  // Next-state, datapath and registered-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_ext_d   = a_ext_q;
    b_sh_d    = b_sh_q;
    idx_d     = idx_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = RUN;
          a_ext_d = {{WIDTH{a[WIDTH-1]}}, a};
          b_sh_d  = {b, 1'b0};
          acc_d   = PW_ZERO;
          idx_d   = IDX_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
        acc_d  = acc_sum_s;
        b_sh_d = {{2{b_sh_q[WIDTH]}}, b_sh_q[WIDTH:2]};
        idx_d  = idx_q + IDX_ONE;
        if ((idx_q == LAST_IDX) || rest_uniform_s) begin
          state_d   = DONE;
          product_d = acc_sum_s;
        end else begin
          state_d = RUN;
        end
`else
        if (idx_q == DONE_IDX) begin
          state_d   = DONE;
          product_d = acc_q;
        end else begin
          acc_d  = acc_sum_s;
          b_sh_d = {{2{b_sh_q[WIDTH]}}, b_sh_q[WIDTH:2]};
          idx_d  = idx_q + IDX_ONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  // Sequencer state, datapath and handshake outputs; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= PW_ZERO;
      a_ext_q     <= PW_ZERO;
      b_sh_q      <= {(WIDTH+1){1'b0}};
      idx_q       <= IDX_ZERO;
      product_q   <= PW_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_ext_q     <= a_ext_d;
      b_sh_q      <= b_sh_d;
      idx_q       <= idx_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq (WIDTH=16): stimulus pushes expected products,
// an independent monitor pops and compares on every out_valid&&out_ready.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          sent = 0;
  int          recv = 0;
  int          rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [31:0] scb[$];

  booth_mul_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Consumer-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare each accepted product against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      recv++;
      if (scb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_product actual=0x%08h expected=none", product);
      end else begin
        check("product", product, scb.pop_front());
      end
    end
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [31:0] exp);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    scb.push_back(exp);
    sent++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (scb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(scb.size()), 32'd0);
  endtask

  logic [15:0] ta[14] = '{16'd0, 16'd1, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000,
                          16'h7FFF, 16'h8000, 16'd3, 16'd123, 16'h1234, 16'd1000, 16'hFFFE};
  logic [15:0] tbv[14] = '{16'd1234, 16'd1, 16'd1, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF,
                           16'hFFFF, 16'd1, 16'd5, 16'hFFD3, 16'h0010, 16'd1000, 16'd3};
  logic [31:0] te[14] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001,
                          32'h3FFF_0001, 32'h4000_0000, 32'hC000_8000, 32'hFFFF_8001,
                          32'hFFFF_8000, 32'h0000_000F, 32'hFFFF_EA61, 32'h0001_2340,
                          32'h000F_4240, 32'hFFFF_FFFA};

  initial begin
    int lat;
    int exp_lat;
    int sa;
    int sb2;
    logic [15:0] ra;
    logic [15:0] rb;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", product, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 3*5: product and accept-to-out_valid latency.
`ifdef BOOTH_MUL_SEQ_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 9;
`endif
    rdy_mode = 1;
    issue(16'd3, 16'd5, 32'd15);
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    drain();

    // Directed table with random consumer backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 14; i++) begin
      issue(ta[i], tbv[i], te[i]);
    end
    drain();

    // Random operand pairs, expected from plain integer multiplication.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      sa = $signed(ra);
      sb2 = $signed(rb);
      issue(ra, rb, 32'(sa * sb2));
    end
    drain();

    // Backpressure: hold out_ready low in DONE, offer new operands, product must hold.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    issue(16'd100, 16'hFFFD, 32'hFFFF_FED4);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      a = 16'd1;
      b = 16'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_product_hold", product, 32'hFFFF_FED4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    repeat (20) @(posedge clk);
    #1;
    check("bp_no_extra", 32'(recv), 32'(sent));

    // Reset in the middle of RUN discards the operation.
    issue(16'd100, 16'd100, 32'd10000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    scb.delete();
    sent--;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", product, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_output", 32'(out_valid), 32'd0);

    // Operation after reset recovery.
    issue(16'h8000, 16'h8000, 32'h4000_0000);
    drain();
    repeat (5) @(posedge clk);
    check("final_count", 32'(recv), 32'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
